// File: rtl/conv_engine.sv
// Valid-region 3x3 convolution of an unsigned 8-bit image into a result FIFO.
// One output per 11 cycles (9 MAC, 1 drain, 1 push), plus one cycle per FIFO-full stall.
//
// state | meaning
// IDLE  | accept coefficient writes, wait for start
// MAC   | issue 9 pixel reads, accumulate the previous tap's pixel
// DRAIN | accumulate the last pixel, register the saturated result
// PUSH  | push result when the FIFO has room, then advance the window
// DONE  | one-cycle frame-complete pulse
module conv_engine #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_i,
  input  logic              kernel_wen_i,
  input  logic [3:0]        kernel_waddr_i,
  input  logic [7:0]        kernel_wdata_i,
  output logic              pix_ren_o,
  output logic [ADDR_W-1:0] pix_addr_o,
  input  logic [7:0]        pix_rdata_i,
  input  logic              res_full_i,
  output logic              res_wenable_o,
  output logic [15:0]       res_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, PUSH, DONE} state_t;

  state_t             state_q;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   col_q;
  logic [3:0]         tap_q;
  logic signed [19:0] acc_q;
  logic signed [7:0]  coeff_q [9];
  logic [15:0]        res_data_q;

  logic [1:0]         tap_r;
  logic [1:0]         tap_c;
  logic [3:0]         mac_sel;
  logic signed [7:0]  coeff_sel;
  logic signed [16:0] pix_ext;
  logic signed [16:0] coef_ext;
  logic signed [16:0] prod;
  logic signed [19:0] acc_d;
  logic               last_pos;
  logic [ADDR_W-1:0]  addr_raw;

  function automatic logic [15:0] sat16(input logic signed [19:0] v);
    if (v > 20'sd32767)
      return 16'h7FFF;
    else if (v < -20'sd32768)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

  always_comb begin
    tap_r = 2'd0;
    tap_c = 2'd0;
    case (tap_q)
      4'd1: begin tap_r = 2'd0; tap_c = 2'd1; end
      4'd2: begin tap_r = 2'd0; tap_c = 2'd2; end
      4'd3: begin tap_r = 2'd1; tap_c = 2'd0; end
      4'd4: begin tap_r = 2'd1; tap_c = 2'd1; end
      4'd5: begin tap_r = 2'd1; tap_c = 2'd2; end
      4'd6: begin tap_r = 2'd2; tap_c = 2'd0; end
      4'd7: begin tap_r = 2'd2; tap_c = 2'd1; end
      4'd8: begin tap_r = 2'd2; tap_c = 2'd2; end
      default: begin tap_r = 2'd0; tap_c = 2'd0; end
    endcase
  end

  // The pixel arriving now belongs to the previous tap; in DRAIN that is tap 8.
  assign mac_sel   = (state_q == DRAIN) ? 4'd8 : (tap_q - 4'd1);
  assign coeff_sel = coeff_q[mac_sel];
  assign pix_ext   = {9'd0, pix_rdata_i};
  assign coef_ext  = {{9{coeff_sel[7]}}, coeff_sel};
  assign prod      = pix_ext * coef_ext;
  assign acc_d     = acc_q + {{3{prod[16]}}, prod};

  assign last_pos = (row_q == ROW_W'(IMG_H - 3)) && (col_q == COL_W'(IMG_W - 3));

  assign addr_raw = (ADDR_W'(row_q) + ADDR_W'(tap_r)) * ADDR_W'(IMG_W)
                  + ADDR_W'(col_q) + ADDR_W'(tap_c);

  assign pix_ren_o     = (state_q == MAC);
  assign pix_addr_o    = pix_ren_o ? addr_raw : '0;
  assign res_wenable_o = (state_q == PUSH) && !res_full_i;
  assign res_data_o    = res_data_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      tap_q      <= '0;
      acc_q      <= '0;
      res_data_q <= '0;
      for (int k = 0; k < 9; k++) coeff_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          for (int k = 0; k < 9; k++)
            if (kernel_wen_i && kernel_waddr_i == 4'(k))
              coeff_q[k] <= kernel_wdata_i;
          if (start_i) begin
            row_q   <= '0;
            col_q   <= '0;
            tap_q   <= '0;
            acc_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (tap_q != 4'd0) acc_q <= acc_d;
          if (tap_q == 4'd8) begin
            tap_q   <= '0;
            state_q <= DRAIN;
          end else begin
            tap_q <= tap_q + 4'd1;
          end
        end
        DRAIN: begin
          acc_q      <= acc_d;
          res_data_q <= sat16(acc_d);
          state_q    <= PUSH;
        end
        PUSH: begin
          if (!res_full_i) begin
            if (last_pos) begin
              state_q <= DONE;
            end else begin
              if (col_q == COL_W'(IMG_W - 3)) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
              end else begin
                col_q <= col_q + 1'b1;
              end
              acc_q   <= '0;
              tap_q   <= '0;
              state_q <= MAC;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
